// File: rtl/over_counter.sv
// Completed-over counter for the match tracker: counts rising edges of
// over_complete, saturates at MAX_OVERS and flags end of innings.
module over_counter #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MAX_OVERS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             over_complete,
  output logic [WIDTH-1:0] overs,
  output logic             over_pulse,
  output logic             innings_done
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_OVERS);

  logic             prev_oc;
  logic             event_c;
  logic             inc_c;
  logic [WIDTH-1:0] next_overs_c;

  // Rising edge of over_complete; out-of-range counts are treated as saturated
  always_comb begin
    event_c      = over_complete & ~prev_oc;
    inc_c        = event_c && (overs < MAX_CNT);
    next_overs_c = overs;
    if (inc_c) begin
      next_overs_c = overs + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_oc      <= 1'b0;
      overs        <= '0;
      over_pulse   <= 1'b0;
      innings_done <= 1'b0;
    end else begin
      prev_oc      <= over_complete;
      overs        <= next_overs_c;
      over_pulse   <= inc_c;
      innings_done <= (next_overs_c == MAX_CNT);
    end
  end

endmodule

// File: tb/tb_over_counter.sv
// Self-checking bench for over_counter: directed scenarios plus randomized
// stimulus against a behavioural over-count model.
module tb_over_counter;

  localparam int unsigned WIDTH     = 5;
  localparam int unsigned MAX_OVERS = 20;

  logic             clk;
  logic             reset;
  logic             over_complete;
  logic [WIDTH-1:0] overs;
  logic             over_pulse;
  logic             innings_done;

  int checks;
  int errors;

  // Reference model state
  int m_overs;
  int m_prev;
  int m_pulse;
  int m_done;

  over_counter #(.WIDTH(WIDTH), .MAX_OVERS(MAX_OVERS)) dut (
    .clk          (clk),
    .reset        (reset),
    .over_complete(over_complete),
    .overs        (overs),
    .over_pulse   (over_pulse),
    .innings_done (innings_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an over is a sampled 0->1 of over_complete, capped at the limit
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_overs = 0;
      m_prev  = 0;
      m_pulse = 0;
      m_done  = 0;
    end else begin
      if (over_complete === 1'b1 && m_prev == 0 && m_overs < MAX_OVERS) begin
        m_overs = m_overs + 1;
        m_pulse = 1;
      end else begin
        m_pulse = 0;
      end
      m_prev = (over_complete === 1'b1) ? 1 : 0;
      m_done = (m_overs == MAX_OVERS) ? 1 : 0;
    end
  end

  // Drive over_complete for one cycle; returns at the following falling edge
  task automatic step(input logic oc);
    over_complete = oc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    over_complete = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    over_complete = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (overs !== '0 || over_pulse !== 1'b0 || innings_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: overs=%0d pulse=%b done=%b, required 0/0/0", overs, over_pulse, innings_done);
    end
    reset = 1'b1;
    step(1'b0);
    checks++;
    if (overs !== '0 || over_pulse !== 1'b0 || innings_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: overs=%0d pulse=%b done=%b, required 0/0/0", overs, over_pulse, innings_done);
    end
  endtask

  task automatic test_five_overs();
    int pulses;
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1);
      if (over_pulse === 1'b1) pulses++;
      checks++;
      if (overs !== WIDTH'(i) || over_pulse !== 1'b1) begin
        errors++;
        $display("FAIL five_overs_inc: over %0d overs=%0d pulse=%b, required %0d/1", i, overs, over_pulse, i);
      end
      step(1'b0);
      if (over_pulse === 1'b1) pulses++;
      checks++;
      if (overs !== WIDTH'(i) || over_pulse !== 1'b0) begin
        errors++;
        $display("FAIL five_overs_gap: over %0d overs=%0d pulse=%b, required %0d/0", i, overs, over_pulse, i);
      end
    end
    checks++;
    if (pulses != 5 || innings_done !== 1'b0) begin
      errors++;
      $display("FAIL five_overs_summary: pulses=%0d done=%b, required 5/0", pulses, innings_done);
    end
  endtask

  task automatic test_held_level();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      if (over_pulse === 1'b1) pulses++;
      checks++;
      if (overs !== WIDTH'(6)) begin
        errors++;
        $display("FAIL held_level_overs: cycle %0d overs=%0d, required 6", i, overs);
      end
    end
    step(1'b0);
    checks++;
    if (pulses != 1 || overs !== WIDTH'(6)) begin
      errors++;
      $display("FAIL held_level_pulses: pulses=%0d overs=%0d, required 1/6", pulses, overs);
    end
  endtask

  task automatic test_saturation();
    int exp_overs;
    apply_reset();
    @(negedge clk);
    for (int i = 1; i <= 22; i++) begin
      exp_overs = (i < int'(MAX_OVERS)) ? i : int'(MAX_OVERS);
      step(1'b1);
      checks++;
      if (overs !== WIDTH'(exp_overs) || over_pulse !== logic'(i <= int'(MAX_OVERS))
          || innings_done !== logic'(i >= int'(MAX_OVERS))) begin
        errors++;
        $display("FAIL saturation_edge: pulse %0d overs=%0d pulse=%b done=%b, required %0d/%b/%b",
                 i, overs, over_pulse, innings_done, exp_overs,
                 logic'(i <= int'(MAX_OVERS)), logic'(i >= int'(MAX_OVERS)));
      end
      step(1'b0);
      checks++;
      if (overs !== WIDTH'(exp_overs) || over_pulse !== 1'b0
          || innings_done !== logic'(i >= int'(MAX_OVERS))) begin
        errors++;
        $display("FAIL saturation_gap: pulse %0d overs=%0d pulse=%b done=%b, required %0d/0/%b",
                 i, overs, over_pulse, innings_done, exp_overs, logic'(i >= int'(MAX_OVERS)));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      step(1'b0);
    end
    checks++;
    if (overs !== WIDTH'(3)) begin
      errors++;
      $display("FAIL async_precount: overs=%0d, required 3", overs);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (overs !== '0 || over_pulse !== 1'b0 || innings_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: overs=%0d pulse=%b done=%b, required 0/0/0", overs, over_pulse, innings_done);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1);
    checks++;
    if (overs !== WIDTH'(1) || over_pulse !== 1'b1) begin
      errors++;
      $display("FAIL async_after_release: overs=%0d pulse=%b, required 1/1", overs, over_pulse);
    end
    step(1'b0);
  endtask

  task automatic test_release_high();
    @(negedge clk);
    reset = 1'b0;
    over_complete = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (overs !== '0 || over_pulse !== 1'b0) begin
      errors++;
      $display("FAIL release_high_held: overs=%0d pulse=%b, required 0/0", overs, over_pulse);
    end
    reset = 1'b1;
    step(1'b1);
    checks++;
    if (overs !== WIDTH'(1) || over_pulse !== 1'b1) begin
      errors++;
      $display("FAIL release_high_first_edge: overs=%0d pulse=%b, required 1/1", overs, over_pulse);
    end
    step(1'b1);
    checks++;
    if (overs !== WIDTH'(1) || over_pulse !== 1'b0) begin
      errors++;
      $display("FAIL release_high_still_held: overs=%0d pulse=%b, required 1/0", overs, over_pulse);
    end
    step(1'b0);
  endtask

  task automatic test_random();
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (overs !== '0 || over_pulse !== 1'b0 || innings_done !== 1'b0) begin
          errors++;
          $display("FAIL random_async_reset: iter %0d overs=%0d pulse=%b done=%b, required 0/0/0",
                   i, overs, over_pulse, innings_done);
        end
        @(negedge clk);
        reset = 1'b1;
      end
      step(logic'($urandom_range(0, 99) < 45));
      checks++;
      if (overs !== WIDTH'(m_overs) || over_pulse !== logic'(m_pulse) || innings_done !== logic'(m_done)) begin
        errors++;
        $display("FAIL random_model: iter %0d overs=%0d pulse=%b done=%b, required %0d/%0d/%0d",
                 i, overs, over_pulse, innings_done, m_overs, m_pulse, m_done);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    over_complete = 1'b0;
    test_reset();
    test_five_overs();
    test_held_level();
    test_saturation();
    test_async_reset();
    test_release_high();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
